// File: rtl/lsu_param_pkg.sv
// Shared types and default widths for the per-thread load/store unit.
package lsu_param_pkg;

    localparam int DEF_ADDR_BITS      = 8;
    localparam int DEF_DATA_BITS      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Core scheduler phases, as driven onto core_state.
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        LSU_ERR_NONE     = 2'b00,
        LSU_ERR_TIMEOUT  = 2'b01,
        LSU_ERR_CONFLICT = 2'b10,
        LSU_ERR_RANGE    = 2'b11
    } lsu_err_t;

    // Counter width able to hold 0..limit (at least one bit).
    function automatic int cnt_bits(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/lsu_param_timeout_counter.sv
// Counts cycles a request sits unanswered; flags the edge on which the
// limit is reached. A limit of 0 removes the counter entirely.
module lsu_param_timeout_counter
    import lsu_param_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (LIMIT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, enable};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int W = cnt_bits(LIMIT);
            logic [W-1:0] count_reg;

            // Cleared when a request is issued, advanced for every stalled cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (enable) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            // The stalled cycle that would bring the count up to LIMIT.
            assign expired = enable && (count_reg == W'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/lsu_param.sv
// Per-thread load/store unit: turns LDR/STR in the REQUEST phase into a
// single valid/ready memory transaction, returns load data, and reports
// timeout / conflict / range errors.
module lsu_param
    import lsu_param_pkg::*;
#(
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic [1:0]           lsu_error
);

    lsu_state_t           state_reg, state_next;
    lsu_err_t             err_reg, err_next;
    logic                 read_valid_reg, read_valid_next;
    logic                 write_valid_reg, write_valid_next;
    logic [ADDR_BITS-1:0] addr_reg, addr_next;
    logic [DATA_BITS-1:0] wdata_reg, wdata_next;
    logic [DATA_BITS-1:0] out_reg, out_next;

    logic range_bad;
    logic issue;
    logic handshake;
    logic stalled;
    logic expired;

    // Address bits above ADDR_BITS must be zero; nothing to check when equal.
    generate
        if (DATA_BITS > ADDR_BITS) begin : g_range
            assign range_bad = |rs[DATA_BITS-1:ADDR_BITS];
        end else begin : g_no_range
            assign range_bad = 1'b0;
        end
    endgenerate

    assign handshake = (read_valid_reg & mem_read_ready) | (write_valid_reg & mem_write_ready);
    assign stalled   = (read_valid_reg | write_valid_reg) & ~handshake;

    lsu_param_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (issue),
        .enable  (stalled),
        .expired (expired)
    );

    // Next-state and next-output decisions for the request lifecycle.
    always_comb begin
        state_next       = state_reg;
        err_next         = err_reg;
        read_valid_next  = read_valid_reg;
        write_valid_next = write_valid_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        out_next         = out_reg;
        issue            = 1'b0;

        case (state_reg)
            LSU_IDLE: begin
                if (enable && (core_state == CORE_REQUEST) &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    if (decoded_mem_read_enable && decoded_mem_write_enable) begin
                        // Conflict is reported ahead of any range problem.
                        err_next   = LSU_ERR_CONFLICT;
                        state_next = LSU_DONE;
                    end else if (range_bad) begin
                        err_next   = LSU_ERR_RANGE;
                        state_next = LSU_DONE;
                    end else begin
                        issue            = 1'b1;
                        err_next         = LSU_ERR_NONE;
                        addr_next        = rs[ADDR_BITS-1:0];
                        wdata_next       = rt;
                        read_valid_next  = decoded_mem_read_enable;
                        write_valid_next = decoded_mem_write_enable;
                        state_next       = LSU_REQUESTING;
                    end
                end
            end
            LSU_REQUESTING, LSU_WAITING: begin
                // A handshake on the limit edge beats the timeout.
                if (handshake) begin
                    read_valid_next  = 1'b0;
                    write_valid_next = 1'b0;
                    if (read_valid_reg) begin
                        out_next = mem_read_data;
                    end
                    state_next = LSU_DONE;
                end else if (expired) begin
                    read_valid_next  = 1'b0;
                    write_valid_next = 1'b0;
                    err_next         = LSU_ERR_TIMEOUT;
                    state_next       = LSU_DONE;
                end else begin
                    state_next = LSU_WAITING;
                end
            end
            LSU_DONE: begin
                if (core_state == CORE_UPDATE) begin
                    state_next = LSU_IDLE;
                end
            end
            default: begin
                state_next = LSU_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= LSU_IDLE;
            err_reg         <= LSU_ERR_NONE;
            read_valid_reg  <= 1'b0;
            write_valid_reg <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            out_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            err_reg         <= err_next;
            read_valid_reg  <= read_valid_next;
            write_valid_reg <= write_valid_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            out_reg         <= out_next;
        end
    end

    assign mem_read_valid    = read_valid_reg;
    assign mem_read_address  = addr_reg;
    assign mem_write_valid   = write_valid_reg;
    assign mem_write_address = addr_reg;
    assign mem_write_data    = wdata_reg;
    assign lsu_state         = state_reg;
    assign lsu_out           = out_reg;
    assign lsu_error         = err_reg;

endmodule

// File: doc/lsu_param.md
Name: lsu_param

Overview:
- Parametrised per-thread load/store unit: one instance per thread lane inside each compute core.
- Driven by the core state machine (REQUEST/UPDATE phases) and the decoded LDR/STR enables.
- Issues valid/ready read or write transactions to the memory controller and returns load data to the register file.
- Generalises the fixed 8-bit LSU with configurable address/data widths, a request timeout, and a 2-bit error code (timeout, read/write conflict, address out of range).

Parameters:
ADDR_BITS, 8, memory address width; must be <= DATA_BITS.
DATA_BITS, 8, register/memory data width.
TIMEOUT_CYCLES, 64, maximum cycles valid may stay high without ready; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
enable  in  1  thread lane active in current block
core_state  in  3  core_state_t from the core scheduler
decoded_mem_read_enable  in  1  current instruction is LDR
decoded_mem_write_enable  in  1  current instruction is STR
rs  in  DATA_BITS  address operand
rt  in  DATA_BITS  store data operand
mem_read_valid  out  1  read request valid
mem_read_address  out  ADDR_BITS  read address
mem_read_ready  in  1  read accepted, data valid this cycle
mem_read_data  in  DATA_BITS  read return data
mem_write_valid  out  1  write request valid
mem_write_address  out  ADDR_BITS  write address
mem_write_data  out  DATA_BITS  write data
mem_write_ready  in  1  write accepted
lsu_state  out  2  lsu_state_t, observed by the scheduler
lsu_out  out  DATA_BITS  loaded value
lsu_error  out  2  lsu_err_t code

Behaviour:
- Reset (async, reset=0): lsu_state=LSU_IDLE, all valids 0, addresses/data/lsu_out 0, lsu_error=LSU_ERR_NONE, timeout counter 0.
- enable=0: stay in LSU_IDLE and hold all outputs; enable falling mid-transaction does not abort it.
- LSU_IDLE, edge where core_state==REQUEST, enable=1:
  - read_en XOR write_en: lsu_error<=NONE, latch address=rs[ADDR_BITS-1:0] and write data=rt, matching valid<=1, -> LSU_REQUESTING.
  - Both enables set: no request, lsu_error<=LSU_ERR_CONFLICT, -> LSU_DONE.
  - rs[DATA_BITS-1:ADDR_BITS] nonzero (only when DATA_BITS>ADDR_BITS): no request, lsu_error<=LSU_ERR_RANGE, -> LSU_DONE. Conflict takes precedence over range.
  - Neither enable set: stay LSU_IDLE.
- Handshake = valid & ready sampled on the same rising edge, allowed in LSU_REQUESTING or LSU_WAITING. On that edge:
  - valid<=0.
  - For a read, lsu_out<=mem_read_data.
  - -> LSU_DONE.
  - Best-case latency: REQUEST edge -> valid high -> handshake edge -> LSU_DONE, i.e. 2 edges.
- LSU_REQUESTING lasts exactly one cycle when there is no handshake, then -> LSU_WAITING.
- Timeout counter: cleared on request issue, increments each cycle valid=1 without ready.
  - When the count reaches TIMEOUT_CYCLES (>0): valid<=0, lsu_error<=LSU_ERR_TIMEOUT, lsu_out unchanged, -> LSU_DONE.
  - Ready on the same edge the limit is reached: the handshake wins and no error is set.
- Address, data and valid stay stable while valid=1; changes on rs/rt are ignored.
- LSU_DONE: lsu_out and lsu_error held; on an edge with core_state==UPDATE -> LSU_IDLE. lsu_error persists until the next accepted request.
- core_state==UPDATE while in REQUESTING/WAITING: ignored.
- ready without valid: ignored.

Decomposition:
- gpu_pkg gains:
  - lsu_err_t enum, 2 bits: LSU_ERR_NONE=00, LSU_ERR_TIMEOUT=01, LSU_ERR_CONFLICT=10, LSU_ERR_RANGE=11.
  - Default width localparams.
- Reuses lsu_state_t and core_state_t from gpu_pkg.
- One sub-module is natural: lsu_timeout_counter (clear/enable/limit, expired flag; static 0 output when limit=0).

Test Plan:
- LDR, rs=0x2A, memory ready 3 cycles after valid with data 0x5C -> mem_read_address=0x2A held throughout, lsu_out=0x5C, DONE, lsu_error=00, then IDLE on UPDATE.
- STR, rs=0x10, rt=0x77, ready high immediately -> mem_write_valid high for exactly 1 cycle with addr 0x10/data 0x77, DONE 2 edges after REQUEST.
- TIMEOUT_CYCLES=4, never ready -> valid drops after 4 valid cycles, lsu_error=01, lsu_out unchanged; next clean LDR clears the error to 00.
- Both enables set at REQUEST -> no valid ever asserted, DONE, lsu_error=10. DATA_BITS=16, ADDR_BITS=8, rs=0x0100 -> lsu_error=11, no request.
- Ready arriving on the same edge as timeout expiry (TIMEOUT_CYCLES=2) -> load completes, lsu_error=00.
- Reset pulled low while in WAITING with valid high -> valid drops asynchronously, state IDLE, all outputs 0; enable=0 with REQUEST -> no activity.
